// File: rtl/fp_mac_sequencer.sv
// Sequences external combinational float multiplier and adder as a registered MAC
// over a stream of operand pairs, returning the dot product with a done pulse.
module fp_mac_sequencer #(
  parameter int unsigned LEN_W    = 8,
  parameter logic [31:0] ACC_INIT = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_a,
  input  logic [31:0]      i_in_b,
  output logic [31:0]      o_mul_a,
  output logic [31:0]      o_mul_b,
  input  logic [31:0]      i_mul_p,
  output logic [31:0]      o_add_a,
  output logic [31:0]      o_add_b,
  input  logic [31:0]      i_add_s,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_result
);

  typedef enum logic [2:0] {StIdle, StLoad, StMul, StAcc, StDone} state_e;

  state_e           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_prod;
  logic [31:0]      r_acc;
  logic [31:0]      r_result;
  logic             w_last;

  // r_len is never zero while in StAcc, so the subtraction cannot underflow there.
  assign w_last = (r_cnt == (r_len - LEN_W'(1)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_len    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_acc    <= ACC_INIT;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_len <= i_len;
            if (i_len == '0) begin
              r_result <= ACC_INIT;
              r_state  <= StDone;
            end else begin
              r_acc   <= ACC_INIT;
              r_cnt   <= '0;
              r_state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (i_in_valid) begin
            r_a     <= i_in_a;
            r_b     <= i_in_b;
            r_state <= StMul;
          end
        end
        StMul: begin
          r_prod  <= i_mul_p;
          r_state <= StAcc;
        end
        StAcc: begin
          r_acc <= i_add_s;
          if (w_last) begin
            r_result <= i_add_s;
            r_state  <= StDone;
          end else begin
            r_cnt   <= r_cnt + LEN_W'(1);
            r_state <= StLoad;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready = (r_state == StLoad);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);
  assign o_mul_a    = r_a;
  assign o_mul_b    = r_b;
  assign o_add_a    = r_prod;
  assign o_add_b    = r_acc;
  assign o_result   = r_result;

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Bench for fp_mac_sequencer: behavioural float units, vector table plus hand sequences,
// expected results queued at start and popped on done.
module tb_fp_mac_sequencer;
  localparam int unsigned LEN_W    = 8;
  localparam logic [31:0] ACC_INIT = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [31:0]      mul_p;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_s;
  logic             busy;
  logic             done;
  logic [31:0]      result;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  fp_mac_sequencer #(
    .LEN_W   (LEN_W),
    .ACC_INIT(ACC_INIT)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_len     (len),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_in_a    (in_a),
    .i_in_b    (in_b),
    .o_mul_a   (mul_a),
    .o_mul_b   (mul_b),
    .i_mul_p   (mul_p),
    .o_add_a   (add_a),
    .o_add_b   (add_b),
    .i_add_s   (add_s),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  // Single <-> double conversion for normal numbers and zero; enough for the test values.
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:23] == 8'd0) begin
      d = {x[31], 63'd0};
    end else begin
      e = {3'd0, x[30:23]} + 11'd896;
      d = {x[31], e, x[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  always_comb begin
    mul_p = r2f(f2r(mul_a) * f2r(mul_b));
    add_s = r2f(f2r(add_a) + f2r(add_b));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // gap[p] = LOAD cycles stalled with in_valid low before pair p (index p%4).
  // poke = edge count after which start is pulsed mid-run (-1 for none).
  typedef struct {
    int          len;
    logic [31:0] a[4];
    logic [31:0] b[4];
    int          gap[4];
    int          poke;
    logic [31:0] exp_res;
    int          exp_edges;
  } vec_t;

  vec_t tbl[6];

  task automatic apply_vec(input vec_t v);
    int          low_cnt      = 0;
    int          pair         = 0;
    int          ready_cycles = 0;
    int          stalls       = 0;
    int          edges        = 0;
    bit          acc_now;
    bit          got_done     = 1'b0;
    logic [31:0] exp_r;
    for (int p = 0; p < v.len; p++) stalls += v.gap[p % 4];
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(v.len);
    sb_q.push_back(v.exp_res);
    in_valid = (v.len > 0) && (v.gap[0] == 0);
    in_a     = in_valid ? v.a[0] : 32'hDEAD_BEEF;
    in_b     = in_valid ? v.b[0] : 32'hDEAD_BEEF;
    while (!got_done && edges < 1000) begin
      acc_now = in_ready && in_valid;
      if (in_ready) ready_cycles++;
      if (in_ready && !in_valid) low_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = (edges == v.poke);
      if (edges == v.poke) len = LEN_W'(1);
      if (acc_now) begin
        pair++;
        low_cnt = 0;
      end
      in_valid = (pair < v.len) && (low_cnt >= v.gap[pair % 4]);
      in_a     = in_valid ? v.a[pair % 4] : 32'hDEAD_BEEF;
      in_b     = in_valid ? v.b[pair % 4] : 32'hDEAD_BEEF;
      if (done) begin
        got_done = 1'b1;
        check("done_edge", 32'(edges), 32'(v.exp_edges));
        check("busy_in_done", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd0, 32'd1);
        end else begin
          exp_r = sb_q.pop_front();
          check("result", result, exp_r);
        end
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("ready_cycles", 32'(ready_cycles), 32'(v.len + stalls));
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    vec_t        fresh;
    int          d1;
    int          d2;
    int          n_done;
    bit          spurious;
    logic [31:0] exp_r;

    // 1.0*2.0 + 3.0*4.0 + 0.5*8.0 = 18.0
    tbl[0] = '{3, '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h0},
               '{32'h40000000, 32'h40800000, 32'h41000000, 32'h0},
               '{0, 0, 0, 0}, -1, 32'h41900000, 10};
    tbl[1] = '{0, '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0},
               '{0, 0, 0, 0}, -1, ACC_INIT, 1};
    // 2.0 + 12.0 = 14.0 with 4 + 5 stall cycles
    tbl[2] = '{2, '{32'h3F800000, 32'h40400000, 32'h0, 32'h0},
               '{32'h40000000, 32'h40800000, 32'h0, 32'h0},
               '{4, 5, 0, 0}, -1, 32'h41600000, 16};
    // start (with len=1) pulsed while in MUL must be ignored
    tbl[3] = '{3, '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h0},
               '{32'h40000000, 32'h40800000, 32'h41000000, 32'h0},
               '{0, 0, 0, 0}, 2, 32'h41900000, 10};
    // -1.5*2.0 + 4.0*0.25 = -2.0
    tbl[4] = '{2, '{32'hBFC00000, 32'h40800000, 32'h0, 32'h0},
               '{32'h40000000, 32'h3E800000, 32'h0, 32'h0},
               '{0, 0, 0, 0}, -1, 32'hC0000000, 7};
    // len = 255 of 1.0*1.0 -> 255.0
    tbl[5] = '{255, '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
               '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
               '{0, 0, 0, 0}, -1, 32'h437F0000, 766};

    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    in_valid = 1'b0;
    in_a     = 32'h0;
    in_b     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {29'd0, busy, done, in_ready}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_add_b", add_b, ACC_INIT);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) apply_vec(tbl[i]);

    // Reset during ACC of the second pair: run discarded, no done pulse.
    @(negedge clk);
    start    = 1'b1;
    len      = LEN_W'(3);
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h40000000;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrun_rst_flags", {30'd0, busy, done}, 32'd0);
    check("midrun_rst_result", result, 32'h0);
    sb_q.delete();
    rst_n    = 1'b1;
    spurious = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) spurious = 1'b1;
    end
    check("no_done_after_rst", 32'(spurious), 32'd0);
    fresh = '{1, '{32'h40000000, 32'h0, 32'h0, 32'h0}, '{32'h40000000, 32'h0, 32'h0, 32'h0},
              '{0, 0, 0, 0}, -1, 32'h40800000, 4};
    apply_vec(fresh);

    // Back-to-back: start held high across DONE starts a second run one cycle later.
    @(negedge clk);
    start    = 1'b1;
    len      = LEN_W'(1);
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h3F800000;
    sb_q.push_back(32'h3F800000);
    sb_q.push_back(32'h3F800000);
    d1     = -1;
    d2     = -1;
    n_done = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) d1 = e;
        if (n_done == 2) begin
          d2    = e;
          start = 1'b0;
        end
        if (sb_q.size() == 0) begin
          check("b2b_sb_empty", 32'd0, 32'd1);
        end else begin
          exp_r = sb_q.pop_front();
          check("b2b_result", result, exp_r);
        end
      end
    end
    check("b2b_done_count", 32'(n_done), 32'd2);
    check("b2b_first_edge", 32'(d1), 32'd4);
    check("b2b_spacing", 32'(d2 - d1), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
